// File: rtl/gshare_branch_predictor.sv
// rtl/gshare_branch_predictor.sv - Tagged BTB with 2-bit counters and a speculative GHR for the IF stage.
// Define BP_GSHARE_EN for gshare indexing; the default build is a bimodal predictor with no GHR.

module gshare_branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 32,
  parameter int IDX_BITS    = $clog2(BTB_ENTRIES),
  parameter int GHR_BITS    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     fetch_pc,
  input  logic                fetch_advance,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_next_pc,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                update_valid,
  input  logic [XLEN-1:0]     update_pc,
  input  logic [GHR_BITS-1:0] update_ghr,
  input  logic                update_is_branch,
  input  logic                update_taken,
  input  logic [XLEN-1:0]     update_target,
  input  logic                update_mispredict
);

  localparam int TAG_W = XLEN - IDX_BITS - 2;

  logic [BTB_ENTRIES-1:0]             valid_q, valid_d;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [BTB_ENTRIES-1:0][XLEN-1:0]   target_q, target_d;
  logic [BTB_ENTRIES-1:0][1:0]        cnt_q, cnt_d;

  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    fetch_tag;
  logic [TAG_W-1:0]    upd_tag;
  logic                fetch_hit;
  logic                upd_hit;
  logic [1:0]          upd_cnt;

  assign fetch_tag = fetch_pc[XLEN-1:IDX_BITS+2];
  assign upd_tag   = update_pc[XLEN-1:IDX_BITS+2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [GHR_BITS-1:0] repair_ghr;
  logic [GHR_BITS-1:0] spec_ghr;

  // Lookup hashes with the live history; training uses the snapshot carried down the pipe.
  assign fetch_idx = fetch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign upd_idx   = update_pc[IDX_BITS+1:2] ^ IDX_BITS'(update_ghr);
  assign pred_ghr  = ghr_q;

  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      assign repair_ghr = update_taken;
      assign spec_ghr   = pred_taken;
    end else begin : g_ghr_shift
      assign repair_ghr = {update_ghr[GHR_BITS-2:0], update_taken};
      assign spec_ghr   = {ghr_q[GHR_BITS-2:0], pred_taken};
    end
  endgenerate

  // A resolved mispredict repairs history and overrides any speculative shift this cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid && update_mispredict) begin
      ghr_d = repair_ghr;
    end else if (fetch_advance && fetch_hit) begin
      ghr_d = spec_ghr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic unused_hist_inputs;

  assign fetch_idx          = fetch_pc[IDX_BITS+1:2];
  assign upd_idx            = update_pc[IDX_BITS+1:2];
  assign pred_ghr           = '0;
  assign unused_hist_inputs = ^{update_ghr, fetch_advance, update_mispredict};
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle write is not visible until next cycle.
  assign fetch_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken   = fetch_hit && cnt_q[fetch_idx][1];
  assign pred_next_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_cnt = cnt_q[upd_idx];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (update_valid) begin
      if (!upd_hit) begin
        if (update_taken) begin
          valid_d[upd_idx]  = 1'b1;
          tag_d[upd_idx]    = upd_tag;
          target_d[upd_idx] = update_target;
          cnt_d[upd_idx]    = update_is_branch ? 2'b10 : 2'b11;
        end
      end else if (update_is_branch) begin
        if (update_taken) begin
          target_d[upd_idx] = update_target;
          if (upd_cnt != 2'b11) begin
            cnt_d[upd_idx] = upd_cnt + 2'd1;
          end
        end else if (upd_cnt != 2'b00) begin
          cnt_d[upd_idx] = upd_cnt - 2'd1;
        end
      end else begin
        // Jumps are unconditional: keep them strongly taken and track the latest target.
        cnt_d[upd_idx]    = 2'b11;
        target_d[upd_idx] = update_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      cnt_q    <= {BTB_ENTRIES{2'b01}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
